fm_cmn_bififo_brd: RTL and testbench

//  Read-side burst drainer for the block-RAM FIFO. Monitors FIFO fill level,

---
 rtl/fm_cmn_bififo_brd_if.sv | 29 ++
 rtl/fm_cmn_bififo_brd.sv | 91 +++++++++
 tb/tb_fm_cmn_bififo_brd.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fm_cmn_bififo_brd_if.sv
// Handshake bundle between the FIFO burst drainer and its surroundings.
// master = the drainer; slave = the FIFO plus the downstream bus master.
interface fm_cmn_bififo_brd_if #(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 8
);
  logic               i_empty;
  logic [P_RANGE:0]   i_dnum;
  logic [P_WIDTH-1:0] i_dt;
  logic               o_renable;
  logic               i_flush;
  logic               o_req;
  logic [P_RANGE:0]   o_len;
  logic               i_ack;
  logic               o_wdvalid;
  logic [P_WIDTH-1:0] o_wd;
  logic               i_wdack;
  logic               o_idle;

  modport master (
    input  i_empty, i_dnum, i_dt, i_flush, i_ack, i_wdack,
    output o_renable, o_req, o_len, o_wdvalid, o_wd, o_idle
  );

  modport slave (
    output i_empty, i_dnum, i_dt, i_flush, i_ack, i_wdack,
    input  o_renable, o_req, o_len, o_wdvalid, o_wd, o_idle
  );
endinterface

// File: rtl/fm_cmn_bififo_brd.sv
// Read-side burst drainer: waits for a full burst (or a flush), requests it with a
// length tag, then streams FIFO words out one accepted beat at a time.
module fm_cmn_bififo_brd #(
  parameter int P_WIDTH = 32,
  parameter int P_RANGE = 8,
  parameter int P_BLEN  = 16
) (
  input  logic                 clk_core,
  input  logic                 rst_x,
  fm_cmn_bififo_brd_if.master  bus
);
  localparam logic [P_RANGE:0] LP_BLEN = (P_RANGE+1)'(P_BLEN);
  localparam logic [P_RANGE:0] LP_ONE  = (P_RANGE+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DATA
  } state_t;

  state_t           r_state;
  logic [P_RANGE:0] r_len;
  logic [P_RANGE:0] r_beat;
  logic             r_flush_pend;
  logic             r_req;

  logic w_in_data;
  logic w_beat_ok;
  logic w_last;
  logic w_full;
  logic w_flush_any;

  assign w_in_data   = (r_state == S_DATA);
  assign w_beat_ok   = w_in_data & ~bus.i_empty & bus.i_wdack;
  assign w_last      = (r_beat == (r_len - LP_ONE));
  assign w_full      = (bus.i_dnum >= LP_BLEN);
  assign w_flush_any = r_flush_pend | bus.i_flush;

  always_ff @(posedge clk_core or negedge rst_x) begin
    if (!rst_x) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_req        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_full) begin
            r_len   <= LP_BLEN;
            r_req   <= 1'b1;
            r_state <= S_REQ;
            // A full burst that happens to take every word also satisfies a flush.
            r_flush_pend <= (bus.i_dnum == LP_BLEN) ? 1'b0 : w_flush_any;
          end else if (w_flush_any & ~bus.i_empty) begin
            r_len        <= bus.i_dnum;
            r_req        <= 1'b1;
            r_state      <= S_REQ;
            r_flush_pend <= 1'b0;
          end else begin
            r_flush_pend <= 1'b0;
          end
        end
        S_REQ: begin
          r_flush_pend <= w_flush_any;
          if (bus.i_ack) begin
            r_req   <= 1'b0;
            r_beat  <= '0;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          r_flush_pend <= w_flush_any;
          if (w_beat_ok) begin
            r_beat <= r_beat + LP_ONE;
            if (w_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Beat path is combinational so an empty FIFO can never be popped.
  assign bus.o_req     = r_req;
  assign bus.o_len     = r_len;
  assign bus.o_wdvalid = w_in_data & ~bus.i_empty;
  assign bus.o_wd      = bus.i_dt;
  assign bus.o_renable = w_beat_ok;
  assign bus.o_idle    = (r_state == S_IDLE) & ~r_flush_pend & ~bus.i_flush;
endmodule

// File: tb/tb_fm_cmn_bififo_brd.sv
// Bench for fm_cmn_bififo_brd: FIFO emulated with a queue, outputs checked each
// cycle against a transaction-level model, plus scenario table and reset corner.
module tb_fm_cmn_bififo_brd;
  localparam int W = 32;
  localparam int R = 8;
  localparam int BLEN = 16;
  localparam int DEPTH = 1 << R;
  localparam int BOUND = 3000;

  logic clk_core = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk_core = ~clk_core;

  fm_cmn_bififo_brd_if #(.P_WIDTH(W), .P_RANGE(R)) bus ();

  fm_cmn_bififo_brd #(.P_WIDTH(W), .P_RANGE(R), .P_BLEN(BLEN)) dut (
    .clk_core (clk_core),
    .rst_x    (rst_x),
    .bus      (bus)
  );

  int total = 0;
  int bad = 0;

  logic [W-1:0] q[$];
  int bursts[$];
  int wcnt, exp_next, beat_cnt, req_age;
  int ack_delay, ack_mode, wd_mode;
  bit tog;

  // model: outstanding request, words left in the burst, its length, pending flush
  bit m_ask, m_pend;
  int m_left, m_len;

  typedef struct {
    int npush; int flush_cyc; int ack_delay; int wd_mode;
    int nb; int len0; int lenl; int remain; bit idle;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ask = 0; m_pend = 0; m_left = 0; m_len = 0;
    req_age = 0; tog = 0;
  endtask

  task automatic cycle(input bit push, input bit fl);
    bit ack, wdack, pop, p, exp_val, exp_ren, exp_idle;
    int n;
    logic [W-1:0] head, popped;
    n = q.size();
    head = (n > 0) ? q[0] : '0;
    bus.i_empty = (n == 0);
    bus.i_dnum  = (R+1)'(n);
    bus.i_dt    = head;
    ack   = (ack_mode == 2) ? 1'($urandom_range(0, 1)) : (req_age >= ack_delay);
    wdack = (wd_mode == 0) ? 1'b1 : (wd_mode == 1) ? tog : 1'($urandom_range(0, 1));
    tog = ~tog;
    bus.i_flush = fl;
    bus.i_ack   = ack;
    bus.i_wdack = wdack;
    #1;
    exp_val  = !m_ask && m_left > 0 && n > 0;
    exp_ren  = exp_val && wdack;
    exp_idle = !m_ask && m_left == 0 && !m_pend && !fl;
    chk("o_req", bus.o_req, m_ask);
    chk("o_len", bus.o_len, m_len);
    chk("o_wdvalid", bus.o_wdvalid, exp_val);
    chk("o_renable", bus.o_renable, exp_ren);
    chk("o_idle", bus.o_idle, exp_idle);
    if (exp_val) chk("o_wd", bus.o_wd, head);
    if (bus.o_req && ack) begin
      bursts.push_back(int'(bus.o_len));
      $display("burst request accepted: len=%0d level=%0d t=%0t", bus.o_len, n, $time);
    end
    pop = bus.o_renable;
    if (!m_ask && m_left == 0) begin
      p = m_pend | fl;
      if (n >= BLEN) begin
        m_len = BLEN; m_ask = 1; m_pend = (n == BLEN) ? 1'b0 : p;
      end else if (p && n > 0) begin
        m_len = n; m_ask = 1; m_pend = 0;
      end else begin
        m_pend = 0;
      end
    end else begin
      m_pend = m_pend | fl;
      if (m_ask) begin
        if (ack) begin m_ask = 0; m_left = m_len; end
      end else if (exp_ren) begin
        m_left--;
      end
    end
    req_age = (bus.o_req && !ack) ? req_age + 1 : 0;
    @(posedge clk_core);
    #1;
    if (pop && q.size() > 0) begin
      popped = q.pop_front();
      beat_cnt++;
      chk("pop_order", popped, exp_next);
      exp_next++;
    end
    if (push && q.size() < DEPTH) begin
      q.push_back(W'(wcnt));
      wcnt++;
    end
    @(negedge clk_core);
  endtask

  task automatic do_reset();
    rst_x = 1'b0;
    bus.i_flush = 0; bus.i_ack = 0; bus.i_wdack = 0;
    bus.i_empty = 1; bus.i_dnum = '0; bus.i_dt = '0;
    q.delete(); bursts.delete();
    exp_next = wcnt; beat_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk_core);
    rst_x = 1'b1;
  endtask

  task automatic run_scn(input vec_t v);
    int cyc, lim;
    ack_delay = v.ack_delay; ack_mode = 0; wd_mode = v.wd_mode;
    lim = ((v.npush > v.flush_cyc) ? v.npush : v.flush_cyc) + 2;
    for (cyc = 0; cyc < BOUND; cyc++) begin
      cycle(cyc < v.npush, cyc == v.flush_cyc);
      if (cyc > lim && !m_ask && m_left == 0 && !m_pend && q.size() < BLEN) break;
    end
    chk("scn_timeout", cyc >= BOUND, 0);
  endtask

  initial begin
    wcnt = 0;
    ack_mode = 0; ack_delay = 0; wd_mode = 0;
    tbl[0] = '{16, -1,  0, 0, 1, 16, 16,  0, 1};
    tbl[1] = '{ 5,  6,  0, 0, 1,  5,  5,  0, 1};
    tbl[2] = '{16, -1,  0, 1, 1, 16, 16,  0, 1};
    tbl[3] = '{30, -1, 20, 0, 1, 16, 16, 14, 1};
    tbl[4] = '{40, 20,  0, 0, 3, 16,  8,  0, 1};
    tbl[5] = '{ 3, -1,  0, 0, 0,  0,  0,  3, 1};
    tbl[6] = '{ 0,  0,  0, 0, 0,  0,  0,  0, 1};
    tbl[7] = '{17, -1,  0, 0, 1, 16, 16,  1, 1};

    do_reset();
    @(negedge clk_core);
    #1;
    chk("rst_o_req", bus.o_req, 0);
    chk("rst_o_len", bus.o_len, 0);
    chk("rst_o_wdvalid", bus.o_wdvalid, 0);
    chk("rst_o_renable", bus.o_renable, 0);
    chk("rst_o_idle", bus.o_idle, 1);
    @(negedge clk_core);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_scn(tbl[i]);
      $display("scenario %0d: bursts=%0d level=%0d", i, bursts.size(), q.size());
      chk($sformatf("s%0d_nburst", i), bursts.size(), tbl[i].nb);
      if (tbl[i].nb > 0) begin
        chk($sformatf("s%0d_len0", i), (bursts.size() > 0) ? bursts[0] : -1, tbl[i].len0);
        chk($sformatf("s%0d_lenlast", i), (bursts.size() > 0) ? bursts[$] : -1, tbl[i].lenl);
      end
      chk($sformatf("s%0d_remain", i), q.size(), tbl[i].remain);
      #1;
      chk($sformatf("s%0d_idle", i), bus.o_idle, tbl[i].idle);
      @(negedge clk_core);
    end

    // reset asserted after the 7th accepted beat of a 16-word burst
    do_reset();
    ack_delay = 0; ack_mode = 0; wd_mode = 0;
    for (int c = 0; c < 200 && beat_cnt < 7; c++) cycle(c < 16, 1'b0);
    chk("mid_beats", beat_cnt, 7);
    rst_x = 1'b0;
    #1;
    chk("mid_o_req", bus.o_req, 0);
    chk("mid_o_len", bus.o_len, 0);
    chk("mid_o_wdvalid", bus.o_wdvalid, 0);
    chk("mid_o_renable", bus.o_renable, 0);
    chk("mid_o_idle", bus.o_idle, 1);
    chk("mid_left", q.size(), 9);
    @(posedge clk_core);
    #1;
    chk("mid_no_pop", bus.o_renable, 0);
    @(negedge clk_core);
    rst_x = 1'b1;

    // randomized traffic
    do_reset();
    ack_mode = 2; wd_mode = 2;
    for (int c = 0; c < 800; c++)
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
    cycle(1'b0, 1'b1);
    begin
      int c;
      for (c = 0; c < BOUND; c++) begin
        cycle(1'b0, 1'b0);
        if (!m_ask && m_left == 0 && !m_pend) break;
      end
      chk("rand_timeout", c >= BOUND, 0);
    end
    chk("rand_drained", q.size(), 0);
    chk("rand_pops", exp_next, wcnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
